// File: rtl/regbank_wb_arbiter.sv
// Round-robin writeback arbiter for the register bank write port, plus a per-register pending scoreboard.
// Grant is combinational; the granted write reaches the bank one cycle later. There is no backpressure: one grant per cycle with any valid request.
module regbank_wb_arbiter #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 32,
  parameter int N_REQ = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*AW-1:0]    req_addr,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   wen,
  output logic [AW-1:0]          wa,
  output logic [WIDTH-1:0]       wd,
  input  logic                   iss_valid,
  input  logic [AW-1:0]          iss_rd,
  input  logic [AW-1:0]          ra1,
  input  logic [AW-1:0]          ra2,
  output logic                   busy1,
  output logic                   busy2,
  output logic                   err_waw
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0] gnt;
  logic [PW-1:0]    gnt_idx;
  logic             any_gnt;
  logic [AW-1:0]    sel_addr;
  logic [WIDTH-1:0] sel_data;

  logic             wen_q, wen_d;
  logic [AW-1:0]    wa_q, wa_d;
  logic [WIDTH-1:0] wd_q, wd_d;
  logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [DEPTH-1:0] pend_q, pend_d;
  logic             err_waw_q, err_waw_d;

  // Search starts one past the last winner and wraps around.
  always_comb begin
    logic [PW-1:0] idx;
    gnt     = '0;
    gnt_idx = rr_ptr_q;
    any_gnt = 1'b0;
    idx     = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = PW'((int'(rr_ptr_q) + k) % N_REQ);
      if (!any_gnt && req_valid[idx]) begin
        any_gnt  = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        sel_addr = req_addr[i*AW +: AW];
        sel_data = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    wen_d    = any_gnt && (sel_addr != '0);
    wa_d     = any_gnt ? sel_addr : wa_q;
    wd_d     = any_gnt ? sel_data : wd_q;
    rr_ptr_d = any_gnt ? gnt_idx : rr_ptr_q;
  end

  // A new issue to a register wins over the commit of its previous producer.
  always_comb begin
    pend_d = pend_q;
    for (int r = 1; r < DEPTH; r++) begin
      if (iss_valid && (iss_rd == AW'(r)))
        pend_d[r] = 1'b1;
      else if (wen_q && (wa_q == AW'(r)))
        pend_d[r] = 1'b0;
    end
    pend_d[0] = 1'b0;
  end

  always_comb begin
    err_waw_d = err_waw_q;
    if (iss_valid && (iss_rd != '0) && pend_q[iss_rd] && !(wen_q && (wa_q == iss_rd)))
      err_waw_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen_q     <= 1'b0;
      wa_q      <= '0;
      wd_q      <= '0;
      rr_ptr_q  <= PW'(N_REQ - 1);
      pend_q    <= '0;
      err_waw_q <= 1'b0;
    end else begin
      wen_q     <= wen_d;
      wa_q      <= wa_d;
      wd_q      <= wd_d;
      rr_ptr_q  <= rr_ptr_d;
      pend_q    <= pend_d;
      err_waw_q <= err_waw_d;
    end
  end

  assign req_ready = rst_n ? gnt : '0;
  assign wen       = wen_q;
  assign wa        = wa_q;
  assign wd        = wd_q;
  assign busy1     = pend_q[ra1];
  assign busy2     = pend_q[ra2];
  assign err_waw   = err_waw_q;

endmodule

// File: tb/tb_regbank_wb_arbiter.sv
// Directed bench for regbank_wb_arbiter: arbitration order, write-port timing, scoreboard and reset.
module tb_regbank_wb_arbiter;

  localparam int WIDTH = 64;
  localparam int DEPTH = 32;
  localparam int N_REQ = 2;
  localparam int AW    = 5;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*AW-1:0]    req_addr;
  logic [N_REQ*WIDTH-1:0] req_data;
  logic [N_REQ-1:0]       req_ready;
  logic                   wen;
  logic [AW-1:0]          wa;
  logic [WIDTH-1:0]       wd;
  logic                   iss_valid;
  logic [AW-1:0]          iss_rd;
  logic [AW-1:0]          ra1;
  logic [AW-1:0]          ra2;
  logic                   busy1;
  logic                   busy2;
  logic                   err_waw;

  int passed = 0;
  int total  = 0;

  regbank_wb_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .N_REQ(N_REQ)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
    .wen(wen), .wa(wa), .wd(wd),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .ra1(ra1), .ra2(ra2),
    .busy1(busy1), .busy2(busy2), .err_waw(err_waw)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    iss_valid = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 2'b01;
    req_addr  = '0;
    req_data  = '0;
    iss_valid = 1'b0;
    iss_rd    = '0;
    ra1       = 5'd5;
    ra2       = 5'd0;
    #2;
    chk("rst_ready", 64'(req_ready), 64'h0);
    chk("rst_wen",   64'(wen), 64'h0);
    chk("rst_wa",    64'(wa), 64'h0);
    chk("rst_wd",    wd, 64'h0);
    chk("rst_busy1", 64'(busy1), 64'h0);
    chk("rst_err",   64'(err_waw), 64'h0);
    req_valid = '0;
    step();
    step();
    rst_n = 1'b1;

    // Single write from requester 0.
    req_valid = 2'b01;
    req_addr  = {5'd0, 5'd5};
    req_data  = {64'h0, 64'h3};
    #1;
    chk("t1_ready", 64'(req_ready), 64'h1);
    step();
    req_valid = '0;
    #1;
    chk("t1_wen", 64'(wen), 64'h1);
    chk("t1_wa",  64'(wa), 64'h5);
    chk("t1_wd",  wd, 64'h3);
    step();
    chk("t1_wen_off", 64'(wen), 64'h0);
    chk("t1_wa_hold", 64'(wa), 64'h5);

    // Both requesters continuously valid from reset: grants alternate.
    do_reset();
    req_valid = 2'b11;
    req_addr  = {5'd2, 5'd1};
    req_data  = {64'h22, 64'h11};
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("t2_ready", 64'(req_ready), (c % 2 == 0) ? 64'h1 : 64'h2);
      if (c > 0) begin
        chk("t2_wen", 64'(wen), 64'h1);
        chk("t2_wa",  64'(wa), ((c - 1) % 2 == 0) ? 64'h1 : 64'h2);
      end
      step();
    end
    req_valid = '0;
    #1;
    chk("t2_wen_last", 64'(wen), 64'h1);
    chk("t2_wa_last",  64'(wa), 64'h2);
    chk("t2_wd_last",  wd, 64'h22);
    step();

    // Write to x0 is granted but never reaches the bank.
    req_valid = 2'b01;
    req_addr  = {5'd2, 5'd0};
    req_data  = {64'h22, 64'hFF};
    #1;
    chk("t3_ready", 64'(req_ready), 64'h1);
    step();
    req_valid = '0;
    #1;
    chk("t3_wen", 64'(wen), 64'h0);
    chk("t3_wd",  wd, 64'hFF);
    req_valid = 2'b11;
    req_addr  = {5'd2, 5'd1};
    #1;
    chk("t3_next_ready", 64'(req_ready), 64'h2);
    step();
    req_valid = '0;
    step();

    // Scoreboard set by issue, cleared after the commit edge.
    iss_valid = 1'b1;
    iss_rd    = 5'd7;
    ra1       = 5'd7;
    step();
    iss_valid = 1'b0;
    #1;
    chk("t4_busy_iss", 64'(busy1), 64'h1);
    req_valid = 2'b01;
    req_addr  = {5'd0, 5'd7};
    req_data  = {64'h0, 64'h77};
    #1;
    chk("t4_busy_req", 64'(busy1), 64'h1);
    step();
    req_valid = '0;
    #1;
    chk("t4_wen",       64'(wen), 64'h1);
    chk("t4_wa",        64'(wa), 64'h7);
    chk("t4_busy_wcyc", 64'(busy1), 64'h1);
    step();
    chk("t4_busy_free", 64'(busy1), 64'h0);
    chk("t4_err",       64'(err_waw), 64'h0);

    // Issue to x0 is ignored.
    iss_valid = 1'b1;
    iss_rd    = 5'd0;
    ra1       = 5'd0;
    step();
    iss_valid = 1'b0;
    chk("t4_x0_busy", 64'(busy1), 64'h0);
    chk("t4_x0_err",  64'(err_waw), 64'h0);

    // Double issue without intervening write raises the sticky error.
    iss_valid = 1'b1;
    iss_rd    = 5'd9;
    ra2       = 5'd9;
    step();
    chk("t5_err_first", 64'(err_waw), 64'h0);
    step();
    iss_valid = 1'b0;
    chk("t5_err_set", 64'(err_waw), 64'h1);
    chk("t5_busy2",   64'(busy2), 64'h1);
    step();
    step();
    chk("t5_err_sticky", 64'(err_waw), 64'h1);
    rst_n = 1'b0;
    #1;
    chk("t5_err_rst",  64'(err_waw), 64'h0);
    chk("t5_busy_rst", 64'(busy2), 64'h0);
    step();
    rst_n = 1'b1;

    // Issue on the same edge the old write to 9 commits: pend stays set, no error.
    iss_valid = 1'b1;
    iss_rd    = 5'd9;
    step();
    iss_valid = 1'b0;
    req_valid = 2'b01;
    req_addr  = {5'd0, 5'd9};
    req_data  = {64'h0, 64'h99};
    step();
    req_valid = '0;
    chk("t5_wen9", 64'(wen), 64'h1);
    iss_valid = 1'b1;
    iss_rd    = 5'd9;
    step();
    iss_valid = 1'b0;
    chk("t5_pend_kept", 64'(busy2), 64'h1);
    chk("t5_no_err",    64'(err_waw), 64'h0);
    chk("t5_wen_off",   64'(wen), 64'h0);

    // Asynchronous reset while a write is in flight.
    req_valid = 2'b10;
    req_addr  = {5'd12, 5'd0};
    req_data  = {64'hC0C0, 64'h0};
    iss_valid = 1'b1;
    iss_rd    = 5'd12;
    step();
    req_valid = '0;
    iss_valid = 1'b0;
    ra1       = 5'd12;
    ra2       = 5'd9;
    #1;
    chk("t6_wen_pre",   64'(wen), 64'h1);
    chk("t6_busy1_pre", 64'(busy1), 64'h1);
    chk("t6_busy2_pre", 64'(busy2), 64'h1);
    rst_n = 1'b0;
    #1;
    chk("t6_wen_rst",   64'(wen), 64'h0);
    chk("t6_busy1_rst", 64'(busy1), 64'h0);
    chk("t6_busy2_rst", 64'(busy2), 64'h0);
    chk("t6_ready_rst", 64'(req_ready), 64'h0);
    rst_n     = 1'b1;
    req_valid = 2'b11;
    req_addr  = {5'd4, 5'd3};
    req_data  = {64'h44, 64'h33};
    #1;
    chk("t6_ready_post", 64'(req_ready), 64'h1);
    step();
    req_valid = '0;
    chk("t6_wa_post",  64'(wa), 64'h3);
    chk("t6_wen_post", 64'(wen), 64'h1);
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/regbank_wb_arbiter.md
Name: regbank_wb_arbiter

Overview:
- Shares the single write port (wen/wa/wd) of the 64x32 register bank between N_REQ writeback requesters (ALU, load unit, multi-cycle units) using round-robin arbitration.
- Registers the granted write and drives the bank's write port directly.
- Keeps a per-register pending scoreboard, set at instruction issue and cleared when the write is committed.
- Decode queries the scoreboard through two lookup ports that mirror the bank's read addresses.

Parameters:
WIDTH, 64, data width of a register
DEPTH, 32, number of registers; AW = $clog2(DEPTH) is derived, not a parameter
N_REQ, 2, number of writeback requesters (2..4)

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  N_REQ  requester i has a write pending
req_addr  in  N_REQ*AW  destination register, requester i in slice [i*AW +: AW]
req_data  in  N_REQ*WIDTH  write data, requester i in slice [i*WIDTH +: WIDTH]
req_ready  out  N_REQ  one-hot grant; requester i is accepted when req_valid[i] & req_ready[i]
wen  out  1  bank write enable
wa  out  AW  bank write address
wd  out  WIDTH  bank write data
iss_valid  in  1  decode issues an instruction that will write iss_rd
iss_rd  in  AW  destination of the issued instruction
ra1  in  AW  scoreboard lookup address 1 (same as bank ra1)
ra2  in  AW  scoreboard lookup address 2 (same as bank ra2)
busy1  out  1  pend[ra1], combinational
busy2  out  1  pend[ra2], combinational
err_waw  out  1  sticky: issue to a register already pending

Behaviour:
- Reset (rst_n low, async): wen=0, wa=0, wd=0, rr_ptr=N_REQ-1 (so requester 0 has first priority), pend all 0, err_waw=0. req_ready=0 while in reset.
- Arbitration is combinational. Search order starts at (rr_ptr+1) mod N_REQ and wraps. The first i with req_valid[i]=1 gets req_ready[i]=1; all other ready bits are 0. If no request is valid, req_ready=0.
- There is no backpressure from the bank, so one write is accepted every cycle that any request is valid.
- On an accepted handshake in cycle t:
  - rr_ptr <= i at the edge ending t.
  - wa/wd <= req_addr[i]/req_data[i].
  - wen <= (req_addr[i] != 0).
  - Write-port latency is 1 cycle: wen is high during t+1 and the bank commits at the edge ending t+1.
- Cycle with no handshake: wen <= 0; wa/wd hold their last values; rr_ptr holds.
- Writes to x0: still granted and rr_ptr still advances, but wen stays 0, so x0 is never written.
- Scoreboard set: iss_valid=1 and iss_rd!=0 sets pend[iss_rd] at the edge. iss_rd=0 is ignored.
- err_waw: set (sticky until reset) when iss_valid=1, iss_rd!=0 and pend[iss_rd] is already 1, unless that same edge also clears it (wen=1 & wa==iss_rd).
- Scoreboard clear: wen=1 clears pend[wa] at the edge on which the bank commits the write.
- Set and clear of the same register on the same edge: set wins, so pend stays 1 (a new producer follows the old write).
- busy1/busy2 reflect the registered pend only. They do not forward the in-flight write; a register shows busy during the wen cycle and shows free the next cycle.
- pend[0] is always 0.
- Reset asserted mid-operation: any registered write is dropped (wen forced 0 immediately) and all pending bits are lost. Decode must be flushed by the same reset.

Test Plan:
1. Reset, then req_valid=01, req_addr0=5, req_data0=3 for one cycle -> req_ready=01 in that cycle; next cycle wen=1, wa=5, wd=3; following cycle wen=0.
2. Both requesters valid continuously (addr0=1, addr1=2), starting after reset -> grants alternate 01,10,01,10; wa sequence 1,2,1,2 one cycle later; wen stays high throughout.
3. req_valid=01, req_addr0=0, req_data0=0xFF -> req_ready=01, wen stays 0, and the next cycle with both valid grants requester 1 first.
4. iss_valid with iss_rd=7, then ra1=7 -> busy1=1. Then a write to 7 is accepted -> busy1=1 through the wen cycle and 0 on the cycle after; err_waw stays 0.
5. Issue rd=9 twice without an intervening write -> err_waw=1 and it stays 1 until rst_n is pulled low. Then issue rd=9 on the same edge that wen commits wa=9 -> pend[9] remains 1 and err_waw is not set.
6. Assert rst_n=0 asynchronously while wen=1 -> wen, busy1 and busy2 drop to 0 immediately; after release, requester 0 has first priority.
